// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 receiver with clock de-glitch filter, odd-parity frame check and a one-entry scancode buffer.
module ps2_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       overrun,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] csync_q, csync_d, dsync_q, dsync_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic                   filt_q, filt_d;
   logic [2:0]             bcnt_q, bcnt_d;
   logic [7:0]             sr_q, sr_d, dout_q, dout_d;
   logic                   par_q, par_d, dv_q, dv_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic                   fall, bit_in, timeout, frame_ok, commit;
   always_comb begin
      csync_d = {csync_q[SYNC_STAGES-2:0], ps2_clk};
      dsync_d = {dsync_q[SYNC_STAGES-2:0], ps2_data};
      filt_d  = filt_q;
      fcnt_d  = '0;
      // Count consecutive samples disagreeing with the filtered level; flip after FILTER_LEN of them
      if (csync_q[SYNC_STAGES-1] != filt_q) begin
         fcnt_d = fcnt_q + 1'b1;
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fcnt_d = '0;
         end
      end
      fall     = filt_q & ~filt_d;
      bit_in   = dsync_q[SYNC_STAGES-1];
      timeout  = (state_q != IDLE) && !fall && (tcnt_q == TW'(TIMEOUT_CYC - 1));
      tcnt_d   = (fall || state_q == IDLE || timeout) ? '0 : tcnt_q + 1'b1;
      frame_ok = bit_in && ^{sr_q, par_q};
      commit   = fall && state_q == STOP && frame_ok;
      ferr_d   = timeout || (fall && state_q == STOP && !frame_ok);
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      sr_d     = sr_q;
      par_d    = par_q;
      if (timeout) state_d = IDLE;
      else if (fall) begin
         unique case (state_q)
            IDLE: begin
               state_d = bit_in ? IDLE : DATA;
               bcnt_d  = '0;
            end
            DATA: begin
               sr_d    = {bit_in, sr_q[7:1]};
               bcnt_d  = bcnt_q + 1'b1;
               state_d = (bcnt_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
               par_d   = bit_in;
               state_d = STOP;
            end
            STOP: state_d = IDLE;
         endcase
      end
      dout_d = dout_q;
      dv_d   = dv_q;
      ovr_d  = ovr_q;
      // A read-ack in the commit cycle frees the slot, so the new byte is taken instead of dropped
      if (commit) begin
         if (!dv_q || rd_ack) begin
            dout_d = sr_q;
            dv_d   = 1'b1;
            ovr_d  = rd_ack ? 1'b0 : ovr_q;
         end else ovr_d = 1'b1;
      end else if (rd_ack && dv_q) begin
         dv_d  = 1'b0;
         ovr_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csync_q <= '1;
         dsync_q <= '1;
         fcnt_q  <= '0;
         filt_q  <= 1'b1;
         state_q <= IDLE;
         bcnt_q  <= '0;
         sr_q    <= '0;
         par_q   <= 1'b0;
         tcnt_q  <= '0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         csync_q <= csync_d;
         dsync_q <= dsync_d;
         fcnt_q  <= fcnt_d;
         filt_q  <= filt_d;
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
         sr_q    <= sr_d;
         par_q   <= par_d;
         tcnt_q  <= tcnt_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end
   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign overrun    = ovr_q;
   assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed PS/2 frames against hand-computed scancode, overrun and frame-error expectations.
module tb_ps2_rx;
   localparam int H        = 20;
   localparam int TO       = 500;
   localparam int FALL_LAT = 5;
   logic       clk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rd_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, overrun, frame_err;
   int         n_chk = 0, n_err = 0, ferr_n = 0, ferr_base = 0, dv_drop = 0;
   logic       mon_dv = 1'b0;
   ps2_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_ack(rd_ack),
      .data_out(data_out), .data_valid(data_valid), .overrun(overrun), .frame_err(frame_err)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (frame_err) ferr_n++;
      if (mon_dv && !data_valid) dv_drop++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(H);
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
   endtask
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
      logic [10:0] bits;
      bits = {s, p, d, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(bits[i]);
      ps2_data = 1'b1;
      wait_cyc(H);
   endtask
   task automatic ack;
      rd_ack = 1'b1;
      wait_cyc(1);
      rd_ack = 1'b0;
      wait_cyc(1);
   endtask
   initial begin
      wait_cyc(3);
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      rst = 1'b1;
      wait_cyc(5);
      ferr_base = ferr_n;
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("t1_data", data_out, 8'h1C);
      check("t1_valid", data_valid, 1'b1);
      check("t1_overrun", overrun, 1'b0);
      check("t1_no_ferr", ferr_n - ferr_base, 0);
      ack();
      check("t1_ack_valid", data_valid, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b1, 11);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("t2_data_kept", data_out, 8'hF0);
      check("t2_valid", data_valid, 1'b1);
      check("t2_overrun", overrun, 1'b1);
      ack();
      check("t2_ack_valid", data_valid, 1'b0);
      check("t2_ack_overrun", overrun, 1'b0);
      ack();
      check("t2_idle_ack_valid", data_valid, 1'b0);
      check("t2_idle_ack_data", data_out, 8'hF0);
      ferr_base = ferr_n;
      send_frame(8'h16, 1'b1, 1'b1, 11);
      check("t3_parity_ferr", ferr_n - ferr_base, 1);
      check("t3_valid", data_valid, 1'b0);
      send_frame(8'h16, 1'b0, 1'b1, 11);
      check("t3_good_data", data_out, 8'h16);
      check("t3_good_valid", data_valid, 1'b1);
      ack();
      ferr_base = ferr_n;
      send_frame(8'h1C, 1'b0, 1'b0, 11);
      check("t4_stop_ferr", ferr_n - ferr_base, 1);
      check("t4_valid", data_valid, 1'b0);
      check("t4_data", data_out, 8'h16);
      ferr_base = ferr_n;
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cyc(3);
      ps2_clk  = 1'b1;
      wait_cyc(2);
      ps2_data = 1'b1;
      wait_cyc(30);
      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("t4_glitch_ferr", ferr_n - ferr_base, 0);
      check("t4_glitch_data", data_out, 8'h1C);
      check("t4_glitch_valid", data_valid, 1'b1);
      ack();
      ferr_base = ferr_n;
      send_frame(8'h45, 1'b0, 1'b1, 5);
      wait_cyc(400);
      check("t5_no_early_to", ferr_n - ferr_base, 0);
      wait_cyc(200);
      check("t5_timeout_ferr", ferr_n - ferr_base, 1);
      check("t5_to_valid", data_valid, 1'b0);
      send_frame(8'h45, 1'b0, 1'b1, 11);
      check("t5_data", data_out, 8'h45);
      check("t5_valid", data_valid, 1'b1);
      ferr_base = ferr_n;
      send_frame(8'h29, 1'b0, 1'b1, 6);
      ps2_data = 1'b1;
      wait_cyc(5);
      rst = 1'b0;
      wait_cyc(1);
      check("t6_rst_data", data_out, 8'h00);
      check("t6_rst_valid", data_valid, 1'b0);
      check("t6_rst_overrun", overrun, 1'b0);
      rst = 1'b1;
      wait_cyc(600);
      check("t6_no_ferr", ferr_n - ferr_base, 0);
      send_frame(8'h29, 1'b0, 1'b1, 11);
      check("t6_data", data_out, 8'h29);
      check("t6_valid", data_valid, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1, 10);
      mon_dv   = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(H);
      ps2_clk  = 1'b0;
      wait_cyc(FALL_LAT);
      rd_ack   = 1'b1;
      wait_cyc(1);
      rd_ack   = 1'b0;
      wait_cyc(H);
      ps2_clk  = 1'b1;
      wait_cyc(H);
      mon_dv   = 1'b0;
      check("t6_coinc_data", data_out, 8'h1C);
      check("t6_coinc_valid", data_valid, 1'b1);
      check("t6_coinc_overrun", overrun, 1'b0);
      check("t6_coinc_no_drop", dv_drop, 0);
      check("t6_total_ferr", ferr_n - ferr_base, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
